// File: rtl/prescaler_pkg.sv
// Shared types and constants for the programmable prescaler.
package prescaler_pkg;
   localparam int PRESC_CNT_W = 16;
   localparam int DIV_MIN     = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;
endpackage

// File: rtl/prescaler_shadow.sv
// Divisor shadow register: captures reload requests and swaps them into the
// active divisor only at a half-period boundary (or while idle), with a 1-cycle ack.
module prescaler_shadow
   import prescaler_pkg::*;
#(
   parameter int CNT_W     = PRESC_CNT_W,
   parameter int DIV_RESET = 4
) (
   input  logic             clk_in,
   input  logic             reset_n,
   input  logic             div_wr,
   input  logic [CNT_W-1:0] div_val,
   input  logic             apply_ok,
   output logic [CNT_W-1:0] div_active,
   output logic             div_ack
);
   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic [CNT_W-1:0] active_q, active_d;
   logic [CNT_W-1:0] val_clamped;
   logic             pend_q, pend_d;
   logic             ack_q, ack_d;

   always_comb begin
      val_clamped = (div_val < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : div_val;
      shadow_d    = shadow_q;
      pend_d      = pend_q;
      active_d    = active_q;
      ack_d       = 1'b0;
      if (pend_q && apply_ok) begin
         // A write landing in the apply cycle is the newest value, so it goes live directly.
         active_d = div_wr ? val_clamped : shadow_q;
         if (div_wr)
            shadow_d = val_clamped;
         pend_d = 1'b0;
         ack_d  = 1'b1;
      end else if (div_wr) begin
         shadow_d = val_clamped;
         pend_d   = 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         shadow_q <= CNT_W'(DIV_RESET);
         active_q <= CNT_W'(DIV_RESET);
         pend_q   <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         pend_q   <= pend_d;
         ack_q    <= ack_d;
      end
   end

   assign div_active = active_q;
   assign div_ack    = ack_q;
endmodule

// File: rtl/prescaler_prog.sv
// Runtime-programmable prescaler: run/drain FSM plus half-period counter.
// Optional PRESCALER_SYNC_EN adds a sync_req input that restarts the phase.
module prescaler_prog
   import prescaler_pkg::*;
#(
   parameter int CNT_W     = PRESC_CNT_W,
   parameter int DIV_RESET = 4
) (
   input  logic             clk_in,
   input  logic             reset_n,
   input  logic             en,
   input  logic             div_wr,
   input  logic [CNT_W-1:0] div_val,
`ifdef PRESCALER_SYNC_EN
   input  logic             sync_req,
`endif
   output logic             div_ack,
   output logic             clk_out,
   output logic             tick,
   output logic             busy
);
   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic [CNT_W-1:0] div_active;
   logic [CNT_W-1:0] term_cnt;
   logic             running;
   logic             terminal;
   logic             sync_hit;
   logic             apply_ok;

   assign running  = (state_q != IDLE);
   assign term_cnt = div_active - CNT_W'(1);
   assign terminal = running && (count_q == term_cnt);

`ifdef PRESCALER_SYNC_EN
   assign sync_hit = running && sync_req;
`else
   assign sync_hit = 1'b0;
`endif

   assign apply_ok = terminal || !running || sync_hit;

   prescaler_shadow #(
      .CNT_W     (CNT_W),
      .DIV_RESET (DIV_RESET)
   ) u_shadow (
      .clk_in     (clk_in),
      .reset_n    (reset_n),
      .div_wr     (div_wr),
      .div_val    (div_val),
      .apply_ok   (apply_ok),
      .div_active (div_active),
      .div_ack    (div_ack)
   );

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      clk_out_d = clk_out_q;
      tick_d    = 1'b0;

      if (terminal) begin
         count_d   = '0;
         clk_out_d = ~clk_out_q;
         tick_d    = 1'b1;
      end else if (running) begin
         count_d = count_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            count_d   = '0;
            clk_out_d = 1'b0;
            if (en)
               state_d = RUN;
         end
         RUN: begin
            if (!en) begin
               if (!clk_out_q) begin
                  // Already low: stop at once without emitting a rising edge.
                  state_d   = IDLE;
                  count_d   = '0;
                  clk_out_d = 1'b0;
                  tick_d    = 1'b0;
               end else if (terminal) begin
                  state_d = IDLE;
               end else begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (terminal)
               state_d = en ? RUN : IDLE;
            else if (en)
               state_d = RUN;
         end
         default: state_d = IDLE;
      endcase

      if (sync_hit) begin
         count_d   = '0;
         clk_out_d = 1'b0;
         tick_d    = 1'b0;
         state_d   = en ? RUN : IDLE;
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         count_q   <= '0;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
      end
   end

   assign clk_out = clk_out_q;
   assign tick    = tick_q;
   assign busy    = running;
endmodule

// File: tb/tb_prescaler_prog.sv
// Directed bench for prescaler_prog: per-cycle output traces compared against
// hand-derived waveforms for each scenario.
module tb_prescaler_prog;
   localparam int CNT_W = 16;

   logic             clk_in;
   logic             reset_n;
   logic             en;
   logic             div_wr;
   logic [CNT_W-1:0] div_val;
`ifdef PRESCALER_SYNC_EN
   logic             sync_req;
`endif
   logic             div_ack;
   logic             clk_out;
   logic             tick;
   logic             busy;

   int n_checks = 0;
   int n_errors = 0;

   prescaler_prog #(
      .CNT_W     (CNT_W),
      .DIV_RESET (4)
   ) dut (
      .clk_in  (clk_in),
      .reset_n (reset_n),
      .en      (en),
      .div_wr  (div_wr),
      .div_val (div_val),
`ifdef PRESCALER_SYNC_EN
      .sync_req(sync_req),
`endif
      .div_ack (div_ack),
      .clk_out (clk_out),
      .tick    (tick),
      .busy    (busy)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      en      = 1'b0;
      div_wr  = 1'b0;
      div_val = '0;
      repeat (2) @(posedge clk_in);
      #1;
      reset_n = 1'b1;
   endtask

   // Inputs presented before clock edge k of a scenario.
   task automatic drive(input int scn, input int k);
      en      = 1'b1;
      div_wr  = 1'b0;
      div_val = '0;
      case (scn)
         1: begin div_wr = (k == 3); div_val = 16'd10; end
         2: begin en = (k >= 2); div_wr = (k == 1); div_val = 16'd0; end
         3: en = (k <= 6);
         4: en = (k <= 2);
         5: begin div_wr = (k == 2) || (k == 3); div_val = (k == 2) ? 16'd6 : 16'd3; end
         6: begin div_wr = (k == 2) || (k == 5); div_val = (k == 2) ? 16'd6 : 16'd2; end
         7: begin div_wr = (k == 6); div_val = 16'd10; end
         default: ;
      endcase
   endtask

   // Hand-derived {clk_out, tick, div_ack, busy} just after edge k.
   function automatic logic [3:0] expect_bits(input int scn, input int k);
      logic c, t, a, b;
      c = 1'b0; t = 1'b0; a = 1'b0; b = 1'b1;
      case (scn)
         0: begin c = (((k - 1) / 4) % 2 == 1); t = (k >= 5) && ((k - 1) % 4 == 0); end
         1: begin
            c = (k >= 5 && k <= 14) || (k >= 25 && k <= 34);
            t = (k == 5) || (k == 15) || (k == 25);
            a = (k == 5);
         end
         2: begin c = (k >= 3) && (k % 2 == 1); t = (k >= 3); a = (k == 2); b = (k >= 2); end
         3: begin c = (k >= 5 && k <= 8); t = (k == 5) || (k == 9); b = (k <= 8); end
         4: b = (k <= 2);
         5: begin c = (k >= 5) && (((k - 5) / 3) % 2 == 0); t = (k >= 5) && ((k - 5) % 3 == 0); a = (k == 5); end
         6: begin c = (k >= 5) && (((k - 5) / 2) % 2 == 0); t = (k >= 5) && ((k - 5) % 2 == 0); a = (k == 5); end
         7: begin c = (k >= 5); t = (k == 5); end
         default: ;
      endcase
      return {c, t, a, b};
   endfunction

   task automatic run_scn(input int scn, input string name, input int n, input bit do_reset);
      logic [63:0] got_c, got_t, got_a, got_b;
      logic [63:0] exp_c, exp_t, exp_a, exp_b;
      logic [3:0]  e;
      got_c = '0; got_t = '0; got_a = '0; got_b = '0;
      exp_c = '0; exp_t = '0; exp_a = '0; exp_b = '0;
      if (do_reset)
         apply_reset();
      for (int k = 1; k <= n; k++) begin
         drive(scn, k);
         @(posedge clk_in);
         #1;
         got_c[k-1] = clk_out;
         got_t[k-1] = tick;
         got_a[k-1] = div_ack;
         got_b[k-1] = busy;
         e = expect_bits(scn, k);
         exp_c[k-1] = e[3];
         exp_t[k-1] = e[2];
         exp_a[k-1] = e[1];
         exp_b[k-1] = e[0];
      end
      en     = 1'b0;
      div_wr = 1'b0;
      check_eq({name, ".clk_out"}, got_c, exp_c);
      check_eq({name, ".tick"},    got_t, exp_t);
      check_eq({name, ".div_ack"}, got_a, exp_a);
      check_eq({name, ".busy"},    got_b, exp_b);
      $display("scenario %s: %0d cycles, clk_out trace %h", name, n, got_c);
   endtask

   initial begin
`ifdef PRESCALER_SYNC_EN
      sync_req = 1'b0;
`endif
      apply_reset();
      check_eq("reset.outputs", 64'({clk_out, tick, div_ack, busy}), 64'd0);
      repeat (3) @(posedge clk_in);
      #1;
      check_eq("idle.outputs", 64'({clk_out, tick, div_ack, busy}), 64'd0);

      run_scn(0, "default_div4", 16, 1'b1);
      run_scn(1, "reload_10",    26, 1'b1);
      run_scn(2, "div_zero",     16, 1'b1);
      run_scn(3, "drain_stop",   14, 1'b1);
      run_scn(4, "low_stop",      8, 1'b1);
      run_scn(5, "double_wr",    16, 1'b1);
      run_scn(6, "wr_in_apply",  16, 1'b1);

      // Asynchronous reset while clk_out is high and a reload is pending.
      run_scn(7, "pre_reset", 7, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("async_reset.outputs", 64'({clk_out, tick, div_ack, busy}), 64'd0);
      @(posedge clk_in);
      #1;
      reset_n = 1'b1;
      run_scn(0, "post_reset", 16, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
